// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl -- sequencer for a signed 8x8 multiply-accumulate dot product.
//
// Streams len operand pairs from two buffers (A at base_a, B at base_b),
// gates the returned data into the MAC datapath, waits for the accumulator
// to settle, then captures and presents the result with a valid/ready
// handshake.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start, len        run request and number of operand pairs (IDLE only)
//   base_a, base_b    vector start addresses, latched with start
//   rd_en             read strobe to both operand buffers
//   a_addr, b_addr    buffer read addresses (wrap modulo 2^ADDR_W)
//   a_data, b_data    signed buffer read data, one cycle after rd_en
//   mac_a, mac_b      gated operands to the MAC (zero when no data valid)
//   mac_clr_n         active-low synchronous accumulator clear
//   acc_in            MAC accumulator value
//   busy              high whenever not IDLE
//   res_data          captured result, held until the next capture
//   res_valid         result available; res_ready accepts it
module mac_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        a_data,
    input  logic [7:0]        b_data,
    output logic [7:0]        mac_a,
    output logic [7:0]        mac_b,
    output logic              mac_clr_n,
    input  logic [25:0]       acc_in,
    output logic              busy,
    output logic [25:0]       res_data,
    output logic              res_valid,
    input  logic              res_ready
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN,
        OUT
    } state_t;

    state_t            r_state;
    logic [LEN_W-1:0]  r_len;
    logic [ADDR_W-1:0] r_base_a;
    logic [ADDR_W-1:0] r_base_b;
    logic [LEN_W-1:0]  r_cnt;      // remaining STREAM cycles minus one
    logic              r_drain;    // second DRAIN cycle flag
    logic              r_rd_en;
    logic              r_vld;      // buffer data valid this cycle
    logic [ADDR_W-1:0] r_a_addr;
    logic [ADDR_W-1:0] r_b_addr;
    logic              r_clr_n;
    logic              r_busy;
    logic [25:0]       r_res_data;
    logic              r_res_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_base_a    <= '0;
            r_base_b    <= '0;
            r_cnt       <= '0;
            r_drain     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_vld       <= 1'b0;
            r_a_addr    <= '0;
            r_b_addr    <= '0;
            r_clr_n     <= 1'b1;
            r_busy      <= 1'b0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_vld <= r_rd_en;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= CLR;
                        r_len    <= len;
                        r_base_a <= base_a;
                        r_base_b <= base_b;
                        r_clr_n  <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                CLR: begin
                    r_clr_n <= 1'b1;
                    if (r_len != '0) begin
                        r_state  <= STREAM;
                        r_rd_en  <= 1'b1;
                        r_a_addr <= r_base_a;
                        r_b_addr <= r_base_b;
                        r_cnt    <= r_len - LEN_W'(1);
                    end else begin
                        r_state <= DRAIN;
                        r_drain <= 1'b0;
                    end
                end
                STREAM: begin
                    if (r_cnt == '0) begin
                        r_state <= DRAIN;
                        r_rd_en <= 1'b0;
                        r_drain <= 1'b0;
                    end else begin
                        r_cnt    <= r_cnt - LEN_W'(1);
                        r_a_addr <= r_a_addr + ADDR_W'(1);
                        r_b_addr <= r_b_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // First cycle lets the last product accumulate; the
                    // accumulator is final during the second.
                    if (r_drain) begin
                        r_state     <= OUT;
                        r_res_data  <= acc_in;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd_en     = r_rd_en;
    assign a_addr    = r_a_addr;
    assign b_addr    = r_b_addr;
    assign mac_a     = r_vld ? a_data : '0;
    assign mac_b     = r_vld ? b_data : '0;
    assign mac_clr_n = r_clr_n;
    assign busy      = r_busy;
    assign res_data  = r_res_data;
    assign res_valid = r_res_valid;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl -- directed bench for mac_seq_ctrl with behavioural
// operand buffers and MAC accumulator around the sequencer.
module tb_mac_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [7:0]  base_a;
    logic [7:0]  base_b;
    logic        rd_en;
    logic [7:0]  a_addr;
    logic [7:0]  b_addr;
    logic [7:0]  a_data;
    logic [7:0]  b_data;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic        mac_clr_n;
    logic [25:0] acc_in;
    logic        busy;
    logic [25:0] res_data;
    logic        res_valid;
    logic        res_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic signed [15:0] prod;
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    int n;

    mac_seq_ctrl #(.ADDR_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .base_a(base_a), .base_b(base_b), .rd_en(rd_en),
        .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
        .mac_a(mac_a), .mac_b(mac_b), .mac_clr_n(mac_clr_n), .acc_in(acc_in),
        .busy(busy), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;

    // Operand buffers: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= mem_a[a_addr];
            b_data <= mem_b[b_addr];
        end
    end

    // MAC accumulator with synchronous active-low clear.
    assign prod = $signed(mac_a) * $signed(mac_b);
    always @(posedge clk) begin
        if (!mac_clr_n) acc_in <= '0;
        else            acc_in <= acc_in + {{10{prod[15]}}, prod};
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the first cycle after the start-sampling edge (cycle 1);
    // returns the cycle number of the first res_valid, or limit on timeout.
    task automatic wait_valid(input int limit, output int cyc);
        cyc = 1;
        while (res_valid !== 1'b1 && cyc < limit) begin
            step();
            cyc++;
        end
    endtask

    task automatic pulse_start(input logic [7:0] l, input logic [7:0] ba, input logic [7:0] bb);
        len    = l;
        base_a = ba;
        base_b = bb;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; len = '0; base_a = '0; base_b = '0;
        res_ready = 1'b1; a_data = '0; b_data = '0; acc_in = '0;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        #1 rst = 1'b1;
        #1;
        chk("rst_busy",  busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_clr_n", mac_clr_n, 1);
        chk("rst_valid", res_valid, 0);
        chk("rst_data",  res_data, 0);
        chk("rst_addr",  {a_addr, b_addr}, 16'h0000);
        chk("rst_mac",   {mac_a, mac_b}, 16'h0000);
        step(); step();
        rst = 1'b0;
        step();

        // Basic dot product: {2,-3,4} . {5,6,-7} = -36
        mem_a[8'h10] = 8'd2; mem_a[8'h11] = 8'hFD; mem_a[8'h12] = 8'd4;
        mem_b[8'h20] = 8'd5; mem_b[8'h21] = 8'd6;  mem_b[8'h22] = 8'hF9;
        res_ready = 1'b1;
        pulse_start(8'd3, 8'h10, 8'h20);
        chk("t1_clr_busy", busy, 1);
        chk("t1_clr_n", mac_clr_n, 0);
        chk("t1_clr_rd", rd_en, 0);
        step();
        chk("t1_c2", {rd_en, a_addr, b_addr, mac_clr_n}, {1'b1, 8'h10, 8'h20, 1'b1});
        chk("t1_c2_mac", {mac_a, mac_b}, 16'h0000);
        step();
        chk("t1_c3", {rd_en, a_addr, b_addr}, {1'b1, 8'h11, 8'h21});
        chk("t1_c3_mac", {mac_a, mac_b}, {8'd2, 8'd5});
        step();
        chk("t1_c4", {rd_en, a_addr, b_addr}, {1'b1, 8'h12, 8'h22});
        chk("t1_c4_mac", {mac_a, mac_b}, {8'hFD, 8'd6});
        step();
        chk("t1_c5_rd", rd_en, 0);
        chk("t1_c5_mac", {mac_a, mac_b}, {8'd4, 8'hF9});
        step();
        chk("t1_c6", {rd_en, mac_a, mac_b, res_valid}, 18'd0);
        step();
        chk("t1_c7_valid", res_valid, 1);
        chk("t1_c7_data", res_data, 26'h3FFFFDC);
        step();
        chk("t1_c8_valid", res_valid, 0);
        chk("t1_c8_busy", busy, 0);

        // Zero-length run; start coinciding with the handshake is ignored.
        pulse_start(8'd0, 8'h33, 8'h44);
        chk("t2_clr_n", mac_clr_n, 0);
        chk("t2_c1_rd", rd_en, 0);
        step();
        chk("t2_c2", {rd_en, mac_clr_n, res_valid}, 3'b010);
        step();
        chk("t2_c3", {rd_en, mac_clr_n, res_valid}, 3'b010);
        step();
        chk("t2_c4_valid", res_valid, 1);
        chk("t2_c4_data", res_data, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_hs_start_ign", {busy, res_valid, mac_clr_n}, 3'b001);
        step();
        chk("t2_idle_after", {busy, mac_clr_n}, 2'b01);

        // Address wrap.
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
        exp_b[0] = 8'hFF; exp_b[1] = 8'h00; exp_b[2] = 8'h01; exp_b[3] = 8'h02;
        pulse_start(8'd4, 8'hFE, 8'hFF);
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_addr%0d", i), {rd_en, a_addr, b_addr}, {1'b1, exp_a[i], exp_b[i]});
            step();
        end
        chk("t3_drain_rd", rd_en, 0);
        step(); step();
        chk("t3_valid", res_valid, 1);
        chk("t3_data", res_data, 0);
        step();

        // Full-length run of -128 * -128, result held under backpressure.
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h80;
            mem_b[i] = 8'h80;
        end
        res_ready = 1'b0;
        pulse_start(8'd255, 8'h00, 8'h00);
        wait_valid(400, n);
        chk("t4_latency", n, 259);
        chk("t4_data", res_data, 26'd4177920);
        for (int i = 0; i < 10; i++) begin
            start = i[0];
            len = 8'd1;
            step();
            chk($sformatf("t4_hold%0d", i), {res_valid, busy, res_data}, {1'b1, 1'b1, 26'd4177920});
        end
        start = 1'b0;
        res_ready = 1'b1;
        step();
        chk("t4_accept", {res_valid, busy}, 2'b00);
        chk("t4_data_kept", res_data, 26'd4177920);
        step();
        chk("t4_no_restart", busy, 0);

        // Abort mid-stream, then a fresh single-pair run.
        pulse_start(8'd8, 8'h00, 8'h00);
        step(); step(); step();
        chk("t5_streaming", rd_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_ctrl", {rd_en, busy, res_valid, mac_clr_n}, 4'b0001);
        chk("t5_rst_addr", {a_addr, b_addr}, 16'h0000);
        chk("t5_rst_mac", {mac_a, mac_b}, 16'h0000);
        chk("t5_rst_data", res_data, 0);
        step();
        rst = 1'b0;
        step();
        chk("t5_post_rst", {busy, rd_en, res_valid}, 3'b000);
        mem_a[8'h40] = 8'd3;
        mem_b[8'h50] = 8'd3;
        pulse_start(8'd1, 8'h40, 8'h50);
        chk("t5_fresh_clr", mac_clr_n, 0);
        wait_valid(50, n);
        chk("t5_latency", n, 5);
        chk("t5_data", res_data, 26'd9);
        step();
        chk("t5_done", {res_valid, busy}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
